// File: rtl/imfu_mc_ctrl_pkg.sv
// Shared types and constants for the integer multiply FU issue/result controller.
// MUL_CYCLES_DEF is also the value the multicycle timing constraint is built from.
package imfu_mc_ctrl_pkg;

  typedef enum logic [1:0] {
    IM_MUL    = 2'd0,
    IM_MULH   = 2'd1,
    IM_MULHSU = 2'd2,
    IM_MULHU  = 2'd3
  } im_op_t;

  localparam int IMFU_RSZ       = 32;
  localparam int MUL_CYCLES_DEF = 2;
  localparam int MUL_CNT_W      = 4;

  function automatic bit mul_cycles_legal(input int cycles, input int cnt_w);
    return (cycles >= 1) && (cycles <= ((1 << cnt_w) - 1));
  endfunction

endpackage

// File: rtl/imfu_mc_ctrl_if.sv
// Issue, multiplier-operand and result bundle around the multiply controller.
// master = surrounding EXE logic plus multiply FU; slave = the controller.
interface imfu_mc_ctrl_if #(
  parameter int RSZ = 32
);
  import imfu_mc_ctrl_pkg::*;

  logic           flush;
  logic           iss_valid;
  logic           iss_ready;
  im_op_t         iss_op;
  logic [RSZ-1:0] iss_rs1;
  logic [RSZ-1:0] iss_rs2;
  logic [4:0]     iss_rd_addr;
  logic [RSZ-1:0] mul_rs1;
  logic [RSZ-1:0] mul_rs2;
  im_op_t         mul_op;
  logic [RSZ-1:0] mul_rd_data;
  logic           res_valid;
  logic           res_ready;
  logic [RSZ-1:0] res_data;
  logic [4:0]     res_rd_addr;

  modport master (
    output flush, iss_valid, iss_op, iss_rs1, iss_rs2, iss_rd_addr,
    output mul_rd_data, res_ready,
    input  iss_ready, mul_rs1, mul_rs2, mul_op, res_valid, res_data, res_rd_addr
  );

  modport slave (
    input  flush, iss_valid, iss_op, iss_rs1, iss_rs2, iss_rd_addr,
    input  mul_rd_data, res_ready,
    output iss_ready, mul_rs1, mul_rs2, mul_op, res_valid, res_data, res_rd_addr
  );

endinterface

// File: rtl/imfu_mc_ctrl.sv
// Multicycle multiply controller: holds operands MUL_CYCLES clocks, then registers the product.
// Result valid MUL_CYCLES edges after accept; issue stalls while busy or while the result is not taken.
module imfu_mc_ctrl
  import imfu_mc_ctrl_pkg::*;
#(
  parameter int RSZ        = IMFU_RSZ,
  parameter int MUL_CYCLES = MUL_CYCLES_DEF,
  parameter int CNT_W      = MUL_CNT_W
) (
  input  logic           clk_in,
  input  logic           reset_in,
  imfu_mc_ctrl_if.slave  bus
);

  if (!mul_cycles_legal(MUL_CYCLES, CNT_W)) begin : g_cfg_check
    $error("imfu_mc_ctrl: MUL_CYCLES out of range for CNT_W");
  end

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_CYCLES - 1);

  logic [1:0]       state_q;
  logic [CNT_W-1:0] cnt_q;
  im_op_t           op_q;
  logic [RSZ-1:0]   rs1_q;
  logic [RSZ-1:0]   rs2_q;
  logic [4:0]       rd_q;
  logic             res_valid_q;
  logic [RSZ-1:0]   res_data_q;
  logic [4:0]       res_rd_q;
  logic             accept;

  // Gated by reset so nothing is accepted while the block is held in reset.
  assign bus.iss_ready = reset_in & ~bus.flush &
                         ((state_q == ST_IDLE) | ((state_q == ST_HOLD) & bus.res_ready));
  assign accept        = bus.iss_valid & bus.iss_ready;

  assign bus.mul_rs1     = rs1_q;
  assign bus.mul_rs2     = rs2_q;
  assign bus.mul_op      = op_q;
  assign bus.res_valid   = res_valid_q;
  assign bus.res_data    = res_data_q;
  assign bus.res_rd_addr = res_rd_q;

  // Operands only move on accept, never in CALC, which keeps the multiplier path multicycle-safe.
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      op_q  <= IM_MUL;
      rs1_q <= '0;
      rs2_q <= '0;
      rd_q  <= '0;
    end else if (accept) begin
      op_q  <= bus.iss_op;
      rs1_q <= bus.iss_rs1;
      rs2_q <= bus.iss_rs2;
      rd_q  <= bus.iss_rd_addr;
    end
  end

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_rd_q    <= '0;
    end else if (bus.flush) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      res_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            state_q <= ST_CALC;
            cnt_q   <= CNT_LOAD;
          end
        end
        ST_CALC: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            res_data_q  <= bus.mul_rd_data;
            res_rd_q    <= rd_q;
            res_valid_q <= 1'b1;
            state_q     <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (bus.res_ready) begin
            res_valid_q <= 1'b0;
            if (accept) begin
              state_q <= ST_CALC;
              cnt_q   <= CNT_LOAD;
            end else begin
              state_q <= ST_IDLE;
            end
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          cnt_q       <= '0;
          res_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/imfu_mc_ctrl.md
Name: imfu_mc_ctrl

Overview:
Multicycle issue/result controller for the integer multiply FU (RV32M MUL/MULH/MULHSU/MULHU).
- Upstream: accepts one op from the EXE issue logic over a valid/ready handshake.
- Middle: holds the operands stable on the combinational multiplier inputs for MUL_CYCLES clocks, which makes it a multicycle timing path.
- Downstream: registers the product and offers it to the EXE→MEM result path over a valid/ready handshake.
- Flush is supported for branch/trap kill.

Parameters:
RSZ, 32, register/data width
MUL_CYCLES, 2, clocks operands are held before capture; legal 1..15
CNT_W, 4, width of the hold counter

Ports:
clk_in  input  1  system clock, rising edge
reset_in  input  1  asynchronous, active-low reset
flush  input  1  synchronous kill of in-flight or held op
iss_valid  input  1  issue request
iss_ready  output  1  controller can accept
iss_op  input  2  IM_OP_TYPE (MUL=0, MULH=1, MULHSU=2, MULHU=3)
iss_rs1  input  RSZ  operand 1
iss_rs2  input  RSZ  operand 2
iss_rd_addr  input  5  destination register
mul_rs1  output  RSZ  to multiply FU Rs1_data
mul_rs2  output  RSZ  to multiply FU Rs2_data
mul_op  output  2  to multiply FU op
mul_rd_data  input  RSZ  product from multiply FU
res_valid  output  1  result available
res_ready  input  1  downstream accepts result
res_data  output  RSZ  registered product
res_rd_addr  output  5  registered destination

Behaviour:
- Reset (reset_in=0, async): state=IDLE, cnt=0, all outputs 0. iss_ready is 0 while reset is asserted.
- Operand registers:
  - op_q, rs1_q, rs2_q, rd_q load only on accept (iss_valid & iss_ready).
  - mul_* = the registered operands. They must not change in CALC; this is required for the multicycle constraint.
- States:
  - IDLE → CALC on accept. cnt loads MUL_CYCLES-1.
  - CALC: while cnt≠0, cnt decrements. When cnt==0, res_data←mul_rd_data, res_rd_addr←rd_q, res_valid←1, state→HOLD.
  - HOLD:
    - res_valid & res_ready with no accept: res_valid←0, state→IDLE.
    - res_valid & res_ready with a simultaneous accept: state→CALC, cnt reloads, res_valid←0 next cycle.
    - res_ready=0: res_data, res_rd_addr and res_valid hold unchanged.
- iss_ready = !flush & (state==IDLE | (state==HOLD & res_ready)). Combinational; it does not depend on iss_valid.
- Latency: res_valid asserts after the MUL_CYCLES-th rising edge following the accepting edge. Throughput is one op per MUL_CYCLES+1 clocks with res_ready held at 1.
- Flush (synchronous, highest priority):
  - Next state is IDLE, res_valid←0, cnt←0. Flush overrides capture and handoff.
  - An issue presented in the same cycle is not accepted.
  - A result being handed off (res_valid & res_ready) in the flush cycle counts as delivered. Downstream owns that kill.
- Asynchronous reset during CALC or HOLD discards the op. There is no res_valid pulse afterward.
- Width rules:
  - Arithmetic and sign handling belong to the FU; this block does not alter data.
  - res_data is exactly RSZ bits.
  - cnt never underflows; cnt==0 in CALC means capture.
- MUL_CYCLES=1: capture occurs on the edge after accept.
- Elaboration: assert 1≤MUL_CYCLES≤2^CNT_W-1.

Decomposition:
- IM_OP_TYPE stays in cpu_structs_pkg.
- MUL_CYCLES default becomes a named constant in cpu_params_pkg so the SDC multicycle value and RTL agree.
- The state enum (IDLE, CALC, HOLD) is local to this module.
- No sub-module inside this block. The multiply FU is instantiated beside it in the EXE parent, connected through IMFU_intf. The mul_* ports map onto that interface's master side.

Test Plan:
1. MUL_CYCLES=2, MUL 7×6 (rd=5), res_ready=1 → res_valid high after the 2nd edge after accept, res_data=0x0000002A, res_rd_addr=5, iss_ready low during CALC.
2. MULH 0xFFFFFFFF×0xFFFFFFFF → 0x00000000. MULHU same operands → 0xFFFFFFFE. MULHSU 0x80000000×0x00000002 → 0xFFFFFFFF.
3. Backpressure: result in HOLD, res_ready=0 for 5 cycles → res_data/res_rd_addr/res_valid stable, iss_ready=0. Then res_ready=1 → handoff, IDLE next cycle.
4. Back-to-back: in HOLD, res_ready=1 with iss_valid=1 (MUL 3×4) → accepted that same cycle. Next result 0x0000000C. mul_rs1/mul_rs2 never change during CALC, checked by assertion.
5. Flush in CALC cycle 1, and separately in HOLD with res_ready=0 → IDLE next cycle, no res_valid for the killed op. A concurrent iss_valid during flush is not accepted.
6. Drive reset_in low mid-CALC (between clock edges) → outputs 0 immediately. After release, a fresh MUL 2×2 completes normally with res_data=4. MUL_CYCLES=1 regression: result after 1 edge.
